sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter WriteGap, default 8: cycles the arbiter holds off after issuing a write before the next grant; legal range 1-255.
REQ-002 Parameter ReadTimeout, default 64: maximum cycles to wait for read data; legal range 2-255.
REQ-003 i_clk  in  1  clock; every register is updated on the rising edge.
REQ-004 i_rstn  in  1  reset, asynchronous, active-low.
REQ-005 i_pN_req  in  1  request from port N (N=0,1); held high until o_pN_ack.
REQ-006 i_pN_we  in  1  port N: 1=write, 0=read; held stable while req is high.
REQ-007 i_pN_addr  in  22  port N word address; held stable while req is high.
REQ-008 i_pN_wdata  in  32  port N write data; held stable while req is high.
REQ-009 o_pN_ack  out  1  one-cycle pulse: port N command accepted.
REQ-010 o_pN_rvalid  out  1  one-cycle pulse: o_pN_rdata is valid.
REQ-011 o_pN_rdata  out  32  port N read data; holds its value until the next read completion on that port.
REQ-012 o_timeout  out  1  sticky: a read has timed out.
REQ-013 o_m_en  out  1  memory command strobe, one-cycle pulse.
REQ-014 o_m_we, o_m_addr[21:0], o_m_wdata[31:0]  out  memory command fields; valid while o_m_en is high.
REQ-015 i_m_ready  in  1  memory port can accept a command this cycle.
REQ-016 i_m_rvalid  in  1  memory read-data strobe, one-cycle pulse.
REQ-017 i_m_rdata  in  32  memory read data; valid with i_m_rvalid.

Function
REQ-018 The block SHALL use the states IDLE, WAIT_WR and WAIT_RD.
REQ-019 IDLE, arbitration: grant SHALL occur only when i_m_ready=1 and at least one req is high.
  - Single requester: that port wins.
  - Both requesting: round-robin; the port not granted last wins.
  - After reset: port 0 wins the first tie.
REQ-020 On grant, in the next cycle, the block SHALL:
  - assert o_m_en=1 and o_pN_ack=1 for exactly one cycle;
  - drive o_m_we/addr/wdata with the values captured from the winning port;
  - record the winner as last-granted;
  - enter WAIT_WR if we=1, otherwise WAIT_RD.
REQ-021 WAIT_WR: a counter loaded on entry SHALL run for exactly WriteGap cycles, then return to IDLE; requests are ignored meanwhile.
REQ-022 WAIT_RD on i_m_rvalid=1: the block SHALL register i_m_rdata into the granted port's o_pN_rdata, pulse o_pN_rvalid in the following cycle, and return to IDLE in that same cycle.
REQ-023 WAIT_RD with no i_m_rvalid within ReadTimeout cycles after o_m_en: the block SHALL set o_pN_rdata=0, pulse o_pN_rvalid, set o_timeout=1, and return to IDLE.
REQ-024 i_m_rvalid arriving outside WAIT_RD SHALL be ignored.
REQ-025 Minimum spacing between two o_m_en pulses:
  - after a write: WriteGap+1 cycles;
  - after a read: read latency + 2 cycles.
REQ-026 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-027 i_m_ready low in IDLE SHALL stall grants indefinitely with no ack and no o_m_en.
REQ-028 Only one port's ack/rvalid SHALL be asserted in any cycle, and never the non-granted port's.
REQ-029 o_timeout SHALL clear only on reset.

Reset
REQ-030 While i_rstn=0 the block SHALL be in state IDLE.
REQ-031 While i_rstn=0 every output SHALL be 0: acks, rvalids, o_m_en, o_m_we, o_m_addr, o_m_wdata, both o_pN_rdata and o_timeout.
REQ-032 While i_rstn=0 the round-robin pointer SHALL favour port 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction immediately with no further pulses.
REQ-034 The first grant SHALL be possible in the first cycle after reset release with i_m_ready=1.

Verification
REQ-035 p0 write addr=0x00123, data=0xDEADBEEF, i_m_ready=1 -> o_m_en one cycle later with matching fields and o_p0_ack same cycle; next o_m_en no earlier than 9 cycles later.
REQ-036 Both ports read continuously, memory returns data 3 cycles after o_m_en -> grants alternate p0,p1,p0,p1; each o_pN_rvalid carries its own data; never two acks in one cycle.
REQ-037 p1 read, memory never returns i_m_rvalid -> at cycle 64 after o_m_en, o_p1_rvalid=1, o_p1_rdata=0, o_timeout=1 stays high.
REQ-038 i_m_ready=0 with p0 requesting for 20 cycles -> no o_m_en and no ack; ack one cycle after i_m_ready rises.
REQ-039 i_rstn pulsed low while in WAIT_RD -> all outputs 0; a late i_m_rvalid produces no rvalid; first tie after release goes to p0.
REQ-040 Spurious i_m_rvalid in IDLE -> no o_pN_rvalid and no change to o_pN_rdata.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM command arbiter: round-robin grant, fixed hold-off after writes,
// read-return tracking with a sticky timeout flag. Grant is registered: command and ack appear one cycle later.
module sdram_arbiter #(
  parameter int WriteGap    = 8,
  parameter int ReadTimeout = 64
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_p0_req,
  input  logic        i_p0_we,
  input  logic [21:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  output logic        o_p0_ack,
  output logic        o_p0_rvalid,
  output logic [31:0] o_p0_rdata,
  input  logic        i_p1_req,
  input  logic        i_p1_we,
  input  logic [21:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  output logic        o_p1_ack,
  output logic        o_p1_rvalid,
  output logic [31:0] o_p1_rdata,
  output logic        o_timeout,
  output logic        o_m_en,
  output logic        o_m_we,
  output logic [21:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  input  logic        i_m_ready,
  input  logic        i_m_rvalid,
  input  logic [31:0] i_m_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT_WR, WAIT_RD} state_t;

  localparam logic [7:0] WrLoad = 8'(WriteGap - 1);
  localparam logic [7:0] RdLoad = 8'(ReadTimeout - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        last_gnt;  // also identifies the port owning an outstanding read
  logic        pick;
  logic [31:0] rd_word;

  always_comb begin
    if (i_p0_req && i_p1_req) pick = ~last_gnt;
    else                      pick = i_p1_req;
  end

  // A timed-out read returns zero data to the requester.
  assign rd_word = i_m_rvalid ? i_m_rdata : 32'd0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      last_gnt    <= 1'b1;
      o_p0_ack    <= 1'b0;
      o_p1_ack    <= 1'b0;
      o_p0_rvalid <= 1'b0;
      o_p1_rvalid <= 1'b0;
      o_p0_rdata  <= '0;
      o_p1_rdata  <= '0;
      o_timeout   <= 1'b0;
      o_m_en      <= 1'b0;
      o_m_we      <= 1'b0;
      o_m_addr    <= '0;
      o_m_wdata   <= '0;
    end else begin
      o_p0_ack    <= 1'b0;
      o_p1_ack    <= 1'b0;
      o_p0_rvalid <= 1'b0;
      o_p1_rvalid <= 1'b0;
      o_m_en      <= 1'b0;
      case (state)
        IDLE: begin
          if (i_m_ready && (i_p0_req || i_p1_req)) begin
            o_m_en    <= 1'b1;
            o_p0_ack  <= ~pick;
            o_p1_ack  <= pick;
            o_m_we    <= pick ? i_p1_we    : i_p0_we;
            o_m_addr  <= pick ? i_p1_addr  : i_p0_addr;
            o_m_wdata <= pick ? i_p1_wdata : i_p0_wdata;
            last_gnt  <= pick;
            if (pick ? i_p1_we : i_p0_we) begin
              state <= WAIT_WR;
              cnt   <= WrLoad;
            end else begin
              state <= WAIT_RD;
              cnt   <= RdLoad;
            end
          end
        end
        WAIT_WR: begin
          if (cnt == 8'd0) state <= IDLE;
          else             cnt   <= cnt - 8'd1;
        end
        WAIT_RD: begin
          if (i_m_rvalid || cnt == 8'd0) begin
            if (last_gnt) begin
              o_p1_rdata  <= rd_word;
              o_p1_rvalid <= 1'b1;
            end else begin
              o_p0_rdata  <= rd_word;
              o_p0_rvalid <= 1'b1;
            end
            if (!i_m_rvalid) o_timeout <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: port/memory agents plus a timeline-based reference model.
module tb_sdram_arbiter;
  localparam int WG = 8;
  localparam int RT = 64;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        req[2];
  logic        we[2];
  logic [21:0] addr[2];
  logic [31:0] wdata[2];
  logic [1:0]  ack_o, rv_o;
  logic [31:0] rdata_o[2];
  logic        m_to, m_en, m_we, m_ready, m_rvalid;
  logic [21:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  always #5 i_clk = ~i_clk;

  sdram_arbiter #(.WriteGap(WG), .ReadTimeout(RT)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_p0_req(req[0]), .i_p0_we(we[0]), .i_p0_addr(addr[0]), .i_p0_wdata(wdata[0]),
    .o_p0_ack(ack_o[0]), .o_p0_rvalid(rv_o[0]), .o_p0_rdata(rdata_o[0]),
    .i_p1_req(req[1]), .i_p1_we(we[1]), .i_p1_addr(addr[1]), .i_p1_wdata(wdata[1]),
    .o_p1_ack(ack_o[1]), .o_p1_rvalid(rv_o[1]), .o_p1_rdata(rdata_o[1]),
    .o_timeout(m_to), .o_m_en(m_en), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
    .i_m_ready(m_ready), .i_m_rvalid(m_rvalid), .i_m_rdata(m_rdata)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model: expected outputs after the next edge, plus transaction timeline
  logic [1:0]  e_ack = '0, e_rv = '0;
  logic        e_en = 0, e_we = 0, e_to = 0;
  logic [21:0] e_addr = '0;
  logic [31:0] e_wdata = '0;
  logic [31:0] e_rdata[2];
  int          idle_at = 0, rd_deadline = 0;
  bit          rd_pend = 0, rd_port = 0, last_g = 1;

  // agent configuration: 0 manual, 1 random, 2 back-to-back reads, 3 hold request high
  int mode_req[2];
  int mem_lat = 3;  // -1 never answers, 0 random
  bit rand_ready = 0, rand_spur = 0, spur_force = 0;
  int rv_at = -1;
  logic [31:0] rv_data = '0;

  wire [124:0] obs_v = {ack_o, rv_o, m_en, m_we, m_addr, m_wdata, rdata_o[0], rdata_o[1], m_to};
  wire [124:0] exp_v = {e_ack, e_rv, e_en, e_we, e_addr, e_wdata, e_rdata[0], e_rdata[1], e_to};

  task automatic cycle();
    bit w;
    for (int p = 0; p < 2; p++) begin
      if (req[p] && ack_o[p] && mode_req[p] != 3) req[p] = 0;
      if (!req[p] && (mode_req[p] == 2 || (mode_req[p] == 1 && $urandom_range(0, 3) == 0))) begin
        req[p]   = 1;
        we[p]    = (mode_req[p] == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        addr[p]  = 22'($urandom);
        wdata[p] = $urandom;
      end
    end
    if (m_en && !m_we) begin
      if (mem_lat > 0)      rv_at = cyc + mem_lat;
      else if (mem_lat < 0) rv_at = -1;
      else                  rv_at = ($urandom_range(0, 7) == 0) ? -1 : cyc + int'($urandom_range(1, 6));
      rv_data = $urandom;
    end
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    m_rvalid = (cyc == rv_at) || spur_force || (rand_spur && $urandom_range(0, 31) == 0);
    m_rdata  = (cyc == rv_at) ? rv_data : $urandom;
    if (!i_rstn) begin
      e_ack = 0; e_rv = 0; e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0;
      e_rdata[0] = 0; e_rdata[1] = 0; e_to = 0;
      idle_at = 0; rd_pend = 0; last_g = 1;
    end else begin
      e_ack = 0; e_rv = 0; e_en = 0;
      if (rd_pend) begin
        if (m_rvalid || cyc == rd_deadline) begin
          e_rv[rd_port]    = 1;
          e_rdata[rd_port] = m_rvalid ? m_rdata : 32'd0;
          if (!m_rvalid) e_to = 1;
          rd_pend = 0;
          idle_at = cyc + 1;
        end
      end else if (cyc >= idle_at && m_ready && (req[0] || req[1])) begin
        w = (req[0] && req[1]) ? !last_g : req[1];
        last_g = w; e_ack[w] = 1; e_en = 1;
        e_we = we[w]; e_addr = addr[w]; e_wdata = wdata[w];
        if (we[w]) idle_at = cyc + 1 + WG;
        else begin
          rd_pend = 1; rd_port = w; rd_deadline = cyc + RT;
        end
      end
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    i_rstn = 0;
    mode_req[0] = 0; mode_req[1] = 0;
    req[0] = 0; req[1] = 0;
    repeat (3) cycle();
    i_rstn = 1;
  endtask

  task automatic test_reset();
    req[0] = 1; req[1] = 1; we[0] = 1; we[1] = 1; m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (obs_v !== '0) begin failures++; $display("FAIL reset_zero cyc=%0d got=%h exp=0", cyc, obs_v); end
    end
    i_rstn = 1;
    cycle();
    checks++;
    if (ack_o !== 2'b01) begin failures++; $display("FAIL reset_first_tie got=%b exp=01", ack_o); end
    for (int i = 0; i < 25; i++) begin
      if (i > 0) cycle();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
  endtask

  task automatic test_write_gap();
    int start, prev;
    do_reset();
    req[0] = 1; we[0] = 1; addr[0] = 22'h00123; wdata[0] = 32'hDEADBEEF; m_ready = 1; mode_req[0] = 3;
    start = cyc; prev = -1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL wr_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      if (m_en) begin
        checks++;
        if (prev < 0) begin
          if (cyc != start + 1 || ack_o !== 2'b01 || m_we !== 1'b1 || m_addr !== 22'h00123 || m_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_first cyc=%0d exp_cyc=%0d ack=%b addr=%h data=%h", cyc, start + 1, ack_o, m_addr, m_wdata);
          end
        end else if (cyc - prev != WG + 1) begin
          failures++; $display("FAIL wr_gap got=%0d exp=%0d", cyc - prev, WG + 1);
        end
        prev = cyc;
      end
    end
    mode_req[0] = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL wr_drain cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
  endtask

  task automatic test_alternate();
    int exp_port, rd_owner, grants;
    do_reset();
    mode_req[0] = 2; mode_req[1] = 2; mem_lat = 3; m_ready = 1;
    exp_port = 0; rd_owner = -1; grants = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL alt_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      checks++;
      if (ack_o == 2'b11) begin failures++; $display("FAIL alt_two_acks cyc=%0d got=%b", cyc, ack_o); end
      if (ack_o != 2'b00) begin
        checks++;
        if (ack_o[exp_port] !== 1'b1) begin failures++; $display("FAIL alt_order cyc=%0d got=%b exp_port=%0d", cyc, ack_o, exp_port); end
        rd_owner = exp_port; exp_port ^= 1; grants++;
      end
      if (rv_o != 2'b00) begin
        checks++;
        if (rd_owner < 0 || rv_o !== (2'b01 << rd_owner)) begin failures++; $display("FAIL alt_rv_port got=%b owner=%0d", rv_o, rd_owner); end
      end
    end
    checks++;
    if (grants < 10) begin failures++; $display("FAIL alt_grants got=%0d exp>=10", grants); end
    mode_req[0] = 0; mode_req[1] = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL alt_drain cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
  endtask

  task automatic test_timeout();
    int en_c;
    bit seen;
    mem_lat = -1; en_c = -1000; seen = 0;
    req[1] = 1; we[1] = 0; addr[1] = 22'h2ABCD;
    for (int i = 0; i < 90; i++) begin
      cycle();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL to_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      if (m_en) en_c = cyc;
      if (rv_o[1]) begin
        seen = 1;
        checks++;
        if (cyc - en_c != RT || rdata_o[1] !== 32'd0 || m_to !== 1'b1) begin
          failures++; $display("FAIL to_pulse delay=%0d exp=%0d rdata=%h to=%b", cyc - en_c, RT, rdata_o[1], m_to);
        end
      end
    end
    checks++;
    if (!seen || m_to !== 1'b1) begin failures++; $display("FAIL to_sticky seen=%0d to=%b exp=1", seen, m_to); end
  endtask

  task automatic test_ready_stall();
    m_ready = 0; mem_lat = 2;
    req[0] = 1; we[0] = 0; addr[0] = 22'h0F00D;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (m_en || ack_o != 2'b00) begin failures++; $display("FAIL stall_quiet cyc=%0d en=%b ack=%b", cyc, m_en, ack_o); end
    end
    m_ready = 1;
    cycle();
    checks++;
    if (ack_o !== 2'b01 || m_en !== 1'b1) begin failures++; $display("FAIL stall_release ack=%b en=%b exp 01/1", ack_o, m_en); end
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL stall_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
  endtask

  task automatic test_reset_midread();
    int n;
    mem_lat = 5; m_ready = 1;
    req[1] = 1; we[1] = 0; addr[1] = 22'h11111;
    n = 0;
    while (!m_en && n < 10) begin cycle(); n++; end
    checks++;
    if (!m_en) begin failures++; $display("FAIL midrd_issue en=%b exp=1", m_en); end
    repeat (2) cycle();
    i_rstn = 0;
    req[0] = 1; we[0] = 1; req[1] = 1; we[1] = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (obs_v !== '0) begin failures++; $display("FAIL midrd_reset cyc=%0d got=%h exp=0", cyc, obs_v); end
    end
    i_rstn = 1;
    cycle();
    checks++;
    if (ack_o !== 2'b01) begin failures++; $display("FAIL midrd_tie got=%b exp=01", ack_o); end
    for (int i = 0; i < 25; i++) begin
      cycle();
      checks++;
      if (obs_v !== exp_v || rv_o != 2'b00) begin failures++; $display("FAIL midrd_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
  endtask

  task automatic test_random();
    mode_req[0] = 1; mode_req[1] = 1; mem_lat = 0; rand_ready = 1; rand_spur = 1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    mode_req[0] = 0; mode_req[1] = 0; rand_ready = 0; rand_spur = 0; m_ready = 1;
    for (int i = 0; i < 160; i++) begin
      cycle();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL rand_drain cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
  endtask

  task automatic test_spurious();
    logic [31:0] keep0, keep1;
    keep0 = e_rdata[0]; keep1 = e_rdata[1];
    spur_force = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (rv_o != 2'b00 || rdata_o[0] !== keep0 || rdata_o[1] !== keep1) begin
        failures++; $display("FAIL spur_idle rv=%b rd0=%h/%h rd1=%h/%h", rv_o, rdata_o[0], keep0, rdata_o[1], keep1);
      end
    end
    spur_force = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    e_rdata[0] = '0; e_rdata[1] = '0;
    mode_req[0] = 0; mode_req[1] = 0;
    req[0] = 0; req[1] = 0; we[0] = 0; we[1] = 0;
    addr[0] = '0; addr[1] = '0; wdata[0] = 32'h0000_1111; wdata[1] = 32'h0000_2222;
    m_ready = 0; m_rvalid = 0; m_rdata = '0;
    test_reset();
    test_write_gap();
    test_alternate();
    test_timeout();
    test_ready_stall();
    test_reset_midread();
    test_random();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
